input_conditioner: RTL and testbench



---
 rtl/input_conditioner.sv | 138 +++++++++++++
 tb/tb_input_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input conditioner for the up/down counter front-end.
// Synchronises the raw push-button and direction switch to clk_1, debounces
// each one independently, and presents clean levels plus one-cycle edge pulses.
module input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk_1,
   input  logic rst,
   input  logic x_raw,
   input  logic switch_raw,
   output logic x,
   output logic switch,
   output logic x_rise,
   output logic x_fall,
   output logic switch_chg
);

   localparam int unsigned NumCh = 2;

   // The cycle that moves the FSM into a WAIT state is already the first stable
   // sample, so WAIT accepts on sample DEBOUNCE_CYCLES, when cnt reaches D-2.
   localparam logic [CNT_W-1:0] AcceptCnt =
      (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;
   localparam bit SingleCycle = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      StStableLo = 2'd0,
      StWaitHi   = 2'd1,
      StStableHi = 2'd2,
      StWaitLo   = 2'd3
   } state_e;

   // Channel 0 is the button, channel 1 is the direction switch.
   logic [NumCh-1:0] raw;
   logic [NumCh-1:0] s1_q;
   logic [NumCh-1:0] s2_q;
   logic [NumCh-1:0] level_q;
   logic [NumCh-1:0] rise_q;
   logic [NumCh-1:0] fall_q;
   state_e           state_q [NumCh];
   logic [CNT_W-1:0] cnt_q   [NumCh];

   assign raw = {switch_raw, x_raw};

   // Two-flop synchroniser per channel.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Debounce FSM per channel; level and pulses are registered on the accept edge.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NumCh; i++) begin
            state_q[i] <= StStableLo;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NumCh; i++) begin
            rise_q[i] <= 1'b0;
            fall_q[i] <= 1'b0;
            case (state_q[i])
               StStableLo: begin
                  if (s2_q[i]) begin
                     cnt_q[i] <= '0;
                     if (SingleCycle) begin
                        state_q[i] <= StStableHi;
                        level_q[i] <= 1'b1;
                        rise_q[i]  <= 1'b1;
                     end else begin
                        state_q[i] <= StWaitHi;
                     end
                  end
               end
               StWaitHi: begin
                  if (!s2_q[i]) begin
                     // Bounce: discard the partial count.
                     state_q[i] <= StStableLo;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == AcceptCnt) begin
                     state_q[i] <= StStableHi;
                     level_q[i] <= 1'b1;
                     rise_q[i]  <= 1'b1;
                     cnt_q[i]   <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
               StStableHi: begin
                  if (!s2_q[i]) begin
                     cnt_q[i] <= '0;
                     if (SingleCycle) begin
                        state_q[i] <= StStableLo;
                        level_q[i] <= 1'b0;
                        fall_q[i]  <= 1'b1;
                     end else begin
                        state_q[i] <= StWaitLo;
                     end
                  end
               end
               StWaitLo: begin
                  if (s2_q[i]) begin
                     state_q[i] <= StStableHi;
                     cnt_q[i]   <= '0;
                  end else if (cnt_q[i] == AcceptCnt) begin
                     state_q[i] <= StStableLo;
                     level_q[i] <= 1'b0;
                     fall_q[i]  <= 1'b1;
                     cnt_q[i]   <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                  end
               end
               default: begin
                  state_q[i] <= StStableLo;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign x          = level_q[0];
   assign switch     = level_q[1];
   assign x_rise     = rise_q[0];
   assign x_fall     = fall_q[0];
   assign switch_chg = rise_q[1] | fall_q[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// A run-length model (consecutive differing samples two cycles behind the raw
// input) predicts all outputs every cycle; literal checks pin key edges.
module tb_input_conditioner;

   localparam int unsigned D = 4;

   logic clk_1 = 1'b0;
   logic rst;
   logic x_raw;
   logic switch_raw;
   logic x;
   logic switch;
   logic x_rise;
   logic x_fall;
   logic switch_chg;

   int vectors    = 0;
   int miscompares = 0;
   int edge_n     = 0;

   logic       smp_rst = 1'b0;
   logic [1:0] smp_raw = 2'b00;

   input_conditioner #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk_1     (clk_1),
      .rst       (rst),
      .x_raw     (x_raw),
      .switch_raw(switch_raw),
      .x         (x),
      .switch    (switch),
      .x_rise    (x_rise),
      .x_fall    (x_fall),
      .switch_chg(switch_chg)
   );

   initial forever #5 clk_1 = ~clk_1;

   // Capture what the DUT saw on each rising edge.
   always @(posedge clk_1) begin
      edge_n  <= edge_n + 1;
      smp_rst <= rst;
      smp_raw <= {switch_raw, x_raw};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
      end
   endtask

   // Model: raw reaches the decision point two edges later; a level flips once
   // D consecutive samples there differ from it. Reset clears everything.
   logic [1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0;
   int         m_run [2] = '{0, 0};

   initial begin
      forever begin
         @(negedge clk_1);
         if (edge_n >= 1) begin
            for (int c = 0; c < 2; c++) begin
               if (smp_rst) begin
                  m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_run[c] = 0;
                  m_lvl[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
               end else begin
                  m_rise[c] = 1'b0;
                  m_fall[c] = 1'b0;
                  m_run[c]  = (m_s2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                  if (m_run[c] >= int'(D)) begin
                     m_lvl[c] = ~m_lvl[c];
                     if (m_lvl[c]) m_rise[c] = 1'b1;
                     else          m_fall[c] = 1'b1;
                     m_run[c] = 0;
                  end
                  m_s2[c] = m_s1[c];
                  m_s1[c] = smp_raw[c];
               end
            end
            chk("model_x",          x,          m_lvl[0]);
            chk("model_switch",     switch,     m_lvl[1]);
            chk("model_x_rise",     x_rise,     m_rise[0]);
            chk("model_x_fall",     x_fall,     m_fall[0]);
            chk("model_switch_chg", switch_chg, m_rise[1] | m_fall[1]);
            if (x_rise && x_fall) chk("rise_fall_exclusive", 1, 0);
         end
      end
   end

   // Returns at the falling edge that follows rising edge n.
   task automatic wait_after(input int n);
      while (edge_n < n) @(negedge clk_1);
   endtask

   bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   int rises;
   int falls;

   initial begin
      rst = 1'b1; x_raw = 1'b1; switch_raw = 1'b1;

      // Reset with both inputs high; edges 1..3 are reset edges.
      wait_after(2);
      chk("rst_x", x, 0);
      chk("rst_switch", switch, 0);
      chk("rst_pulses", {x_rise, x_fall, switch_chg}, 0);
      wait_after(3);
      rst = 1'b0;
      wait_after(8);
      chk("post_rst_x_early", x, 0);
      chk("post_rst_sw_early", switch, 0);
      wait_after(9);
      chk("post_rst_x", x, 1);
      chk("post_rst_x_rise", x_rise, 1);
      chk("post_rst_switch", switch, 1);
      chk("post_rst_switch_chg", switch_chg, 1);
      wait_after(10);
      chk("post_rst_x_rise_clear", x_rise, 0);

      // Drop both inputs together.
      wait_after(11);
      x_raw = 1'b0; switch_raw = 1'b0;
      wait_after(17);
      chk("drop_x_fall", x_fall, 1);
      chk("drop_switch_chg", switch_chg, 1);

      // Clean press, raw change before edge 30.
      wait_after(29);
      x_raw = 1'b1;
      wait_after(34);
      chk("press_x_early", x, 0);
      wait_after(35);
      chk("press_x", x, 1);
      chk("press_x_rise", x_rise, 1);
      wait_after(36);
      chk("press_x_rise_clear", x_rise, 0);

      // Release before edge 40.
      wait_after(39);
      x_raw = 1'b0;
      wait_after(45);
      chk("release_x", x, 0);
      chk("release_x_fall", x_fall, 1);

      // Bounce 1,0,1,1,0,1 before edges 50..55, then held high.
      rises = 0; falls = 0;
      for (int k = 0; k < 6; k++) begin
         wait_after(49 + k);
         x_raw = pat[k];
         if (k > 0) begin
            if (x_rise) rises++;
            if (x_fall) falls++;
         end
      end
      for (int e = 55; e <= 70; e++) begin
         wait_after(e);
         if (x_rise) rises++;
         if (x_fall) falls++;
         if (e == 59) chk("bounce_x_early", x, 0);
         if (e == 60) chk("bounce_x", x, 1);
      end
      chk("bounce_rises", rises, 1);
      chk("bounce_falls", falls, 0);

      // Near-miss: switch high for only three cycles.
      wait_after(74);
      switch_raw = 1'b1;
      wait_after(77);
      switch_raw = 1'b0;
      wait_after(85);
      chk("nearmiss_switch", switch, 0);
      chk("nearmiss_cnt", 32'(dut.cnt_q[1]), 0);

      // Simultaneous toggle of both inputs before edge 90.
      wait_after(89);
      x_raw = 1'b0; switch_raw = 1'b1;
      wait_after(95);
      chk("simul_x_fall", x_fall, 1);
      chk("simul_switch_chg", switch_chg, 1);
      chk("simul_switch", switch, 1);

      // Mid-count reset on edge 103 discards the button count.
      wait_after(99);
      x_raw = 1'b1;
      wait_after(102);
      rst = 1'b1;
      wait_after(103);
      rst = 1'b0;
      chk("midrst_switch_cleared", switch, 0);
      wait_after(108);
      chk("midrst_x_early", x, 0);
      wait_after(109);
      chk("midrst_x", x, 1);
      chk("midrst_x_rise", x_rise, 1);
      chk("midrst_switch_chg", switch_chg, 1);

      wait_after(120);
      @(posedge clk_1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
